// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver:
// segment table (active-low {g,f,e,d,c,b,a}), blank pattern and scan states.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the rightmost entry of the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h27, 7'h03, 7'h20, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_GUARD = 1'b1
    } scan_state_t;

endpackage

// File: rtl/sseg_decode.sv
// Combinational hex-to-segment decoder with a forced-dark override.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    // Table lookup unless the digit is forced dark
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = SEG_TABLE[value];
        end
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver: shadowed digit data, refresh counter,
// DRIVE/GUARD scan FSM with a one-cycle dark gap, and registered active-low outputs.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*N_DIGITS-1:0]         hex_in,
    input  logic [N_DIGITS-1:0]           dp_in,
    input  logic [N_DIGITS-1:0]           blank_in,
    input  logic                          load,
    output logic [N_DIGITS-1:0]           an,
    output logic [6:0]                    sseg,
    output logic                          dp,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [4*N_DIGITS-1:0] hex_sh_r;
    logic [N_DIGITS-1:0]   dp_sh_r;
    logic [N_DIGITS-1:0]   blank_sh_r;
    logic [CNT_W-1:0]      cnt_r,   cnt_nxt_s;
    logic [IDX_W-1:0]      idx_r,   idx_nxt_s;
    scan_state_t           state_r, state_nxt_s;
    logic                  tc_s;
    logic [N_DIGITS-1:0]   upper_zero_s;
    logic [3:0]            cur_hex_s;
    logic                  blank_s;
    logic [6:0]            seg_s;
    logic [N_DIGITS-1:0]   an_nxt_s;
    logic [6:0]            sseg_nxt_s;
    logic                  dp_nxt_s;
    logic [N_DIGITS-1:0]   an_r;
    logic [6:0]            sseg_r;
    logic                  dp_r;
    logic [IDX_W-1:0]      digit_idx_r;

    // Shadow capture of the display data on the load strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_sh_r   <= '0;
            dp_sh_r    <= '0;
            blank_sh_r <= '0;
        end else if (load) begin
            hex_sh_r   <= hex_in;
            dp_sh_r    <= dp_in;
            blank_sh_r <= blank_in;
        end else begin
            hex_sh_r   <= hex_sh_r;
            dp_sh_r    <= dp_sh_r;
            blank_sh_r <= blank_sh_r;
        end
    end

    assign tc_s = (cnt_r == CNT_W'(REFRESH_DIV - 1));

    // Next refresh count, digit index and scan state
    always_comb begin
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        idx_nxt_s   = idx_r;
        state_nxt_s = state_r;
        if (tc_s) begin
            cnt_nxt_s = '0;
            if (idx_r == IDX_W'(N_DIGITS - 1)) begin
                idx_nxt_s = '0;
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_nxt_s = idx_r;
        end
        case (state_r)
            ST_DRIVE: state_nxt_s = tc_s ? ST_GUARD : ST_DRIVE;
            ST_GUARD: state_nxt_s = ST_DRIVE;
            default:  state_nxt_s = ST_GUARD;
        endcase
    end

    // Scan state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            idx_r   <= '0;
            state_r <= ST_GUARD;
        end else begin
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    // upper_zero_s[i]: digit i and every more significant digit hold zero
    always_comb begin
        upper_zero_s = '0;
        upper_zero_s[N_DIGITS-1] = (hex_sh_r[4*N_DIGITS-1 -: 4] == 4'h0);
        for (int i = N_DIGITS - 2; i >= 0; i--) begin
            upper_zero_s[i] = upper_zero_s[i+1] && (hex_sh_r[4*i +: 4] == 4'h0);
        end
    end

    assign cur_hex_s = hex_sh_r[{idx_r, 2'b00} +: 4];
    assign blank_s   = blank_sh_r[idx_r] ||
                       (LZ_BLANK && (idx_r != '0) && upper_zero_s[idx_r]);

    sseg_decode u_decode (
        .value (cur_hex_s),
        .blank (blank_s),
        .seg   (seg_s)
    );

    // Output pattern for the current scan slot; GUARD keeps everything dark
    always_comb begin
        an_nxt_s   = '1;
        sseg_nxt_s = SEG_BLANK;
        dp_nxt_s   = 1'b1;
        if (state_r == ST_DRIVE) begin
            an_nxt_s   = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_r);
            sseg_nxt_s = seg_s;
            dp_nxt_s   = ~dp_sh_r[idx_r];
        end else begin
            an_nxt_s   = '1;
            sseg_nxt_s = SEG_BLANK;
            dp_nxt_s   = 1'b1;
        end
    end

    // Registered outputs, digit_idx kept aligned with an/sseg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r        <= '1;
            sseg_r      <= SEG_BLANK;
            dp_r        <= 1'b1;
            digit_idx_r <= '0;
        end else begin
            an_r        <= an_nxt_s;
            sseg_r      <= sseg_nxt_s;
            dp_r        <= dp_nxt_s;
            digit_idx_r <= idx_r;
        end
    end

    assign an        = an_r;
    assign sseg      = sseg_r;
    assign dp        = dp_r;
    assign digit_idx = digit_idx_r;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (4 digits, 4-cycle slots): a
// cycle-count reference model checked every cycle plus directed literal checks.
module tb_sseg_scan_driver;

    localparam int N = 4;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic [1:0]  digit_idx;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .N_DIGITS    (N),
        .REFRESH_DIV (R),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hex_in    (hex_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .load      (load),
        .an        (an),
        .sseg      (sseg),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;
            4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;
            4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;
            4'hA: seg_of = 7'h20;  4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h27;  4'hD: seg_of = 7'h21;
            4'hE: seg_of = 7'h06;  default: seg_of = 7'h0E;
        endcase
    endfunction

    // Reference model: k_m edges since reset; slot position k%R (0 = gap),
    // digit (k/R)%N; outputs after an edge show the situation before it.
    int          k_m      = 0;
    logic [15:0] sh_hex   = 16'h0;
    logic [3:0]  sh_dp    = 4'h0;
    logic [3:0]  sh_blank = 4'h0;
    logic [3:0]  exp_an   = 4'hF;
    logic [6:0]  exp_sseg = 7'h7F;
    logic        exp_dp   = 1'b1;
    logic [1:0]  exp_idx  = 2'd0;

    always @(posedge clk or negedge rst_n) begin
        int  pos;
        int  d;
        bit  bl;
        bit  lz;
        if (!rst_n) begin
            k_m = 0; sh_hex = 16'h0; sh_dp = 4'h0; sh_blank = 4'h0;
            exp_an = 4'hF; exp_sseg = 7'h7F; exp_dp = 1'b1; exp_idx = 2'd0;
        end else begin
            pos = k_m % R;
            d   = (k_m / R) % N;
            exp_idx = 2'(d);
            if (pos == 0) begin
                exp_an = 4'hF; exp_sseg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an    = 4'hF;
                exp_an[d] = 1'b0;
                lz = (d != 0);
                for (int j = d; j < N; j++) begin
                    if (sh_hex[4*j +: 4] != 4'h0) lz = 1'b0;
                end
                bl = sh_blank[d] || lz;
                exp_sseg = bl ? 7'h7F : seg_of(sh_hex[4*d +: 4]);
                exp_dp   = ~sh_dp[d];
            end
            if (load) begin
                sh_hex = hex_in; sh_dp = dp_in; sh_blank = blank_in;
            end
            k_m++;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_an",   32'(an),        32'(exp_an));
            chk("model_sseg", 32'(sseg),      32'(exp_sseg));
            chk("model_dp",   32'(dp),        32'(exp_dp));
            chk("model_idx",  32'(digit_idx), 32'(exp_idx));
        end
    end

    task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] b);
        hex_in = h; dp_in = p; blank_in = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        hex_in = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
    endtask

    // Wait for the next gap, then for the first drive slot of digit d
    task automatic show(input int d);
        logic [3:0] target;
        int n;
        target = 4'hF;
        target[d] = 1'b0;
        n = 0;
        while (an !== 4'hF && n < 40) begin @(negedge clk); n++; end
        while (an !== target && n < 40) begin @(negedge clk); n++; end
        chk($sformatf("reach_digit%0d", d), 32'(an), 32'(target));
    endtask

    logic [3:0] an_log  [1:16];
    logic [6:0] seg_log [1:16];

    initial begin
        rst_n = 1'b0; load = 1'b0; hex_in = 16'h0; dp_in = 4'h0; blank_in = 4'h0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_sseg", 32'(sseg), 32'h0000007F);
        chk("rst_dp", 32'(dp), 32'h00000001);
        chk("rst_idx", 32'(digit_idx), 32'h00000000);

        // Release with a load of 1234 captured on the first edge
        rst_n = 1'b1; hex_in = 16'h1234; load = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            load = 1'b0;
            an_log[k] = an; seg_log[k] = sseg;
        end
        chk("r030_first_gap", 32'(an_log[1]), 32'hF);
        chk("r030_d0_an", 32'(an_log[2]), 32'hE);
        chk("r030_d0_seg", 32'(seg_log[2]), 32'h19);
        chk("r030_gap_an", 32'(an_log[5]), 32'hF);
        chk("r030_gap_seg", 32'(seg_log[5]), 32'h7F);
        chk("r030_d1_an", 32'(an_log[6]), 32'hD);
        chk("r030_d1_seg", 32'(seg_log[6]), 32'h30);
        chk("r030_d2_an", 32'(an_log[10]), 32'hB);
        chk("r030_d2_seg", 32'(seg_log[10]), 32'h24);
        chk("r030_d3_an", 32'(an_log[14]), 32'h7);
        chk("r030_d3_seg", 32'(seg_log[14]), 32'h79);

        // Leading-zero blanking
        do_load(16'h0050, 4'h0, 4'h0);
        show(3); chk("lz_0050_d3", 32'(sseg), 32'h7F);
        show(2); chk("lz_0050_d2", 32'(sseg), 32'h7F);
        show(1); chk("lz_0050_d1", 32'(sseg), 32'h12);
        show(0); chk("lz_0050_d0", 32'(sseg), 32'h40);
        do_load(16'h0000, 4'h0, 4'h0);
        show(0); chk("lz_0000_d0", 32'(sseg), 32'h40);
        show(1); chk("lz_0000_d1", 32'(sseg), 32'h7F);
        show(3); chk("lz_0000_d3", 32'(sseg), 32'h7F);

        // Forced blank does not hide the decimal point
        do_load(16'h8888, 4'b0100, 4'b0100);
        show(2); chk("blk_d2_seg", 32'(sseg), 32'h7F); chk("blk_d2_dp", 32'(dp), 32'h0);
        show(1); chk("blk_d1_seg", 32'(sseg), 32'h00); chk("blk_d1_dp", 32'(dp), 32'h1);

        // Load in the middle of digit 1's drive slot
        do_load(16'hAAAA, 4'h0, 4'h0);
        show(1); chk("mid_before", 32'(sseg), 32'h20);
        hex_in = 16'hFFFF; load = 1'b1;
        @(negedge clk); load = 1'b0;
        chk("mid_e1_seg", 32'(sseg), 32'h20); chk("mid_e1_an", 32'(an), 32'hD);
        @(negedge clk);
        chk("mid_e2_seg", 32'(sseg), 32'h0E); chk("mid_e2_an", 32'(an), 32'hD);
        chk("mid_e2_idx", 32'(digit_idx), 32'h1);
        @(negedge clk);
        chk("mid_e3_gap", 32'(an), 32'hF);

        // Asynchronous reset in the middle of digit 2
        show(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF); chk("async_sseg", 32'(sseg), 32'h7F);
        chk("async_dp", 32'(dp), 32'h1); chk("async_idx", 32'(digit_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); chk("restart_gap", 32'(an), 32'hF);
        @(negedge clk); chk("restart_d0_an", 32'(an), 32'hE); chk("restart_d0_seg", 32'(sseg), 32'h40);

        // Randomized loads, with one asynchronous reset pulse part way through
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i == 300) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            case ($urandom_range(0, 3))
                0: hex_in = 16'($urandom);
                1: hex_in = 16'($urandom) & 16'h00FF;
                2: hex_in = 16'($urandom) & 16'h000F;
                default: hex_in = 16'($urandom) & 16'h0F0F;
            endcase
            dp_in    = 4'($urandom);
            blank_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            load     = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
